pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Frame-rate game controller for the Pong design. It sequences all game state (paddle positions, ball position and velocity, scores, serve and game-over phases) and presents registered object coordinates to the pixel renderer, which compares them against the VGA timing generator's `x`/`y`. State advances exactly once per video frame, on a one-cycle `frame_tick` raised at the start of vertical blanking, so coordinates never change during active video.

## Interface
Parameters:
- `WIDTH`, 640: active pixels per line.
- `HEIGHT`, 480: active lines per frame.
- `PADDLE_W`, 8: paddle width in pixels.
- `PADDLE_H`, 64: paddle height in pixels.
- `PADDLE_X_L`, 16: left paddle left edge.
- `PADDLE_X_R`, 616: right paddle left edge.
- `BALL_SIZE`, 8: ball edge length in pixels.
- `PADDLE_SPEED`, 4: paddle pixels per frame.
- `BALL_SPEED`, 2: ball pixels per frame, per axis.
- `WIN_SCORE`, 9: score that ends the game.
- `SERVE_FRAMES`, 60: frames spent in SERVE before PLAY.

Ports:
- `clk` in 1: pixel clock.
- `reset` in 1: reset, asynchronous, active-high.
- `frame_tick` in 1: one-cycle pulse, once per frame, at the start of vertical blanking.
- `start` in 1: level input, sampled only on `frame_tick`.
- `btn_l_up`, `btn_l_dn`, `btn_r_up`, `btn_r_dn` in 1 each: synchronised, debounced paddle buttons (level).
- `paddle_l_y`, `paddle_r_y` out 10: paddle top rows.
- `ball_x`, `ball_y` out 10: ball top-left corner.
- `score_l`, `score_r` out 4: scores.
- `game_state` out 2: IDLE=0, SERVE=1, PLAY=2, OVER=3.
- `winner` out 1: 0 = left, 1 = right; valid in OVER.

## Operation
- Reset values:
  - State IDLE.
  - Paddles at (HEIGHT-PADDLE_H)/2 = 208.
  - Ball at ((WIDTH-BALL_SIZE)/2, (HEIGHT-BALL_SIZE)/2) = (316, 236).
  - dx = +, dy = +.
  - Scores 0, `winner` 0, serve counter 0.
- Registers update only on cycles where `frame_tick` = 1. Otherwise all state holds.
- Paddles move in SERVE and PLAY only.
  - up alone: y -= PADDLE_SPEED. down alone: y += PADDLE_SPEED. Both or neither: hold.
  - Clamp to [0, HEIGHT-PADDLE_H].
- Ball and collision logic always uses the pre-update (registered) paddle positions.
- Arithmetic: next positions are computed as 11-bit signed values, then clamped before truncating to 10 bits. No wrap-around is permitted.
- State transitions:
  - IDLE: `start` → SERVE. Scores cleared, counter cleared.
  - SERVE:
    - Ball held at centre.
    - Counter increments each tick.
    - When the counter reaches SERVE_FRAMES-1 → PLAY, counter cleared.
  - PLAY: ball steps ±BALL_SPEED on each axis. Checks, in priority order:
    1. Top/bottom: next_y ≤ 0 → y = 0, dy = +. next_y ≥ HEIGHT-BALL_SIZE → y = HEIGHT-BALL_SIZE, dy = −. Applied independently of the x checks.
    2. Left paddle: dx = −, next_x ≤ PADDLE_X_L+PADDLE_W, and vertical overlap (ball_y+BALL_SIZE > paddle_l_y and ball_y < paddle_l_y+PADDLE_H) → x = PADDLE_X_L+PADDLE_W, dx = +.
    3. Right paddle: dx = +, next_x+BALL_SIZE ≥ PADDLE_X_R, and overlap with `paddle_r_y` → x = PADDLE_X_R-BALL_SIZE, dx = −.
    4. Miss: next_x ≤ 0 → score_r++. next_x ≥ WIDTH-BALL_SIZE → score_l++. On a miss:
       - Ball recentred; dx points toward the player who conceded; dy kept.
       - If the new score equals WIN_SCORE → OVER, `winner` set. Otherwise → SERVE.
  - OVER:
    - Ball frozen at centre, paddles frozen, scores held.
    - `start` → SERVE with scores cleared, paddles recentred.
- Only one side can score per tick (dx is single-signed).
- BALL_SPEED < PADDLE_W, so the ball cannot tunnel through a paddle.
- Reset mid-operation returns everything to the reset values immediately.

## Timing
- All outputs are registered, with no combinational path from any input to any output.
- Latency: outputs reflect the tick's update from the first clock edge that samples `frame_tick` = 1.
- `frame_tick` held high for several cycles is a protocol violation. Behaviour in that case: one update per high cycle.
- `start` and buttons are ignored between ticks.

## Structure
- `pong_pkg` holds:
  - `game_state_t` enum (IDLE, SERVE, PLAY, OVER).
  - Direction type.
  - Default geometry constants shared with the renderer.
- Sub-module `pong_paddle`: a clamped up/down position register with an enable, instantiated twice.
- Ball physics and the FSM live in `pong_game_ctrl`.

## Test plan
- Reset, then 5 ticks with no input → IDLE, paddles 208/208, ball (316,236), scores 0/0. Nothing changes between ticks.
- `start`, hold `btn_l_up` → SERVE; `paddle_l_y` 204, 200, …, 0 after 52 ticks, then stays 0. Both left buttons held → unchanged. Paddles ignore buttons in IDLE.
- SERVE: 60 ticks → PLAY. First PLAY tick gives ball (318,238). After 117 further ticks, y reaches 472 and is clamped; the next tick gives 470.
- Park right paddle at 0, let ball reach x ≥ 632 → score_l = 1, state SERVE, ball (316,236), dx = +.
- Left paddle aligned with ball, ball moving left → x clamps at 24 and dx flips to +. Score unchanged.
- Drive score_l to 9 → OVER, `winner` = 0, ball frozen. `start` → scores 0/0, SERVE. Assert reset mid-PLAY → reset values within the same cycle.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong types and default geometry, used by the game controller and the pixel renderer.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

    localparam int DEF_WIDTH        = 640;
    localparam int DEF_HEIGHT       = 480;
    localparam int DEF_PADDLE_W     = 8;
    localparam int DEF_PADDLE_H     = 64;
    localparam int DEF_PADDLE_X_L   = 16;
    localparam int DEF_PADDLE_X_R   = 616;
    localparam int DEF_BALL_SIZE    = 8;
    localparam int DEF_PADDLE_SPEED = 4;
    localparam int DEF_BALL_SPEED   = 2;
    localparam int DEF_WIN_SCORE    = 9;
    localparam int DEF_SERVE_FRAMES = 60;

    // Clamp a signed intermediate coordinate into [0, hi] before narrowing to 10 bits.
    function automatic logic [9:0] clamp_coord(input logic signed [10:0] v,
                                               input logic signed [10:0] hi);
        if (v < 11'sd0) begin
            return 10'd0;
        end else if (v > hi) begin
            return hi[9:0];
        end else begin
            return v[9:0];
        end
    endfunction

endpackage

// File: rtl/pong_paddle.sv
// Clamped up/down paddle position register; moves one step per enabled cycle.
module pong_paddle
    import pong_pkg::*;
#(
    parameter int HEIGHT   = DEF_HEIGHT,
    parameter int PADDLE_H = DEF_PADDLE_H,
    parameter int SPEED    = DEF_PADDLE_SPEED
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       recenter,
    input  logic       up,
    input  logic       dn,
    output logic [9:0] y
);

    localparam logic signed [10:0] Y_MAX  = 11'(HEIGHT - PADDLE_H);
    localparam logic signed [10:0] STEP   = 11'(SPEED);
    localparam logic [9:0]         Y_HOME = 10'((HEIGHT - PADDLE_H) / 2);

    logic signed [10:0] y_cur;
    logic signed [10:0] y_step;
    logic [9:0]         y_next;

    always_comb begin
        y_cur  = $signed({1'b0, y});
        y_step = y_cur;
        if (up && !dn) begin
            y_step = y_cur - STEP;
        end else if (dn && !up) begin
            y_step = y_cur + STEP;
        end
        y_next = clamp_coord(y_step, Y_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y <= Y_HOME;
        end else if (recenter) begin
            y <= Y_HOME;
        end else if (en) begin
            y <= y_next;
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: paddles, ball physics, scoring and serve/over phases, advanced once per frame_tick.
// state | meaning
// IDLE  | power-up attract, waiting for start
// SERVE | ball parked at centre for SERVE_FRAMES ticks
// PLAY  | ball moving, collisions and scoring evaluated
// OVER  | someone reached WIN_SCORE, waiting for start
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int HEIGHT       = DEF_HEIGHT,
    parameter int PADDLE_W     = DEF_PADDLE_W,
    parameter int PADDLE_H     = DEF_PADDLE_H,
    parameter int PADDLE_X_L   = DEF_PADDLE_X_L,
    parameter int PADDLE_X_R   = DEF_PADDLE_X_R,
    parameter int BALL_SIZE    = DEF_BALL_SIZE,
    parameter int PADDLE_SPEED = DEF_PADDLE_SPEED,
    parameter int BALL_SPEED   = DEF_BALL_SPEED,
    parameter int WIN_SCORE    = DEF_WIN_SCORE,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       btn_l_up,
    input  logic       btn_l_dn,
    input  logic       btn_r_up,
    input  logic       btn_r_dn,
    output logic [9:0] paddle_l_y,
    output logic [9:0] paddle_r_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] game_state,
    output logic       winner
);

    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [9:0]         CENTRE_X   = 10'((WIDTH - BALL_SIZE) / 2);
    localparam logic [9:0]         CENTRE_Y   = 10'((HEIGHT - BALL_SIZE) / 2);
    localparam logic signed [10:0] BS         = 11'(BALL_SPEED);
    localparam logic signed [10:0] BALL_MAX_X = 11'(WIDTH - BALL_SIZE);
    localparam logic signed [10:0] BALL_MAX_Y = 11'(HEIGHT - BALL_SIZE);
    localparam logic signed [10:0] L_FACE     = 11'(PADDLE_X_L + PADDLE_W);
    localparam logic signed [10:0] R_STOP     = 11'(PADDLE_X_R - BALL_SIZE);
    localparam logic [10:0]        BALL_SZ    = 11'(BALL_SIZE);
    localparam logic [10:0]        PAD_H      = 11'(PADDLE_H);
    localparam logic [3:0]         WIN        = 4'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

    game_state_t        state, state_n;
    dir_t               dx, dx_n, dy, dy_n;
    logic [9:0]         ball_x_n, ball_y_n;
    logic [3:0]         score_l_n, score_r_n;
    logic               winner_n;
    logic [CNT_W-1:0]   serve_cnt, serve_cnt_n;

    logic signed [10:0] step_x, step_y;
    logic               overlap_l, overlap_r, hit_l, hit_r;
    logic               paddle_en, paddle_recenter;

    assign paddle_en       = frame_tick && (state == SERVE || state == PLAY);
    assign paddle_recenter = frame_tick && start && (state == OVER);

    pong_paddle #(
        .HEIGHT   (HEIGHT),
        .PADDLE_H (PADDLE_H),
        .SPEED    (PADDLE_SPEED)
    ) u_paddle_l (
        .clk      (clk),
        .reset    (reset),
        .en       (paddle_en),
        .recenter (paddle_recenter),
        .up       (btn_l_up),
        .dn       (btn_l_dn),
        .y        (paddle_l_y)
    );

    pong_paddle #(
        .HEIGHT   (HEIGHT),
        .PADDLE_H (PADDLE_H),
        .SPEED    (PADDLE_SPEED)
    ) u_paddle_r (
        .clk      (clk),
        .reset    (reset),
        .en       (paddle_en),
        .recenter (paddle_recenter),
        .up       (btn_r_up),
        .dn       (btn_r_dn),
        .y        (paddle_r_y)
    );

    // Collision tests use the registered ball and paddle positions, not this tick's paddle move.
    always_comb begin
        step_x    = (dx == DIR_NEG) ? $signed({1'b0, ball_x}) - BS : $signed({1'b0, ball_x}) + BS;
        step_y    = (dy == DIR_NEG) ? $signed({1'b0, ball_y}) - BS : $signed({1'b0, ball_y}) + BS;
        overlap_l = ({1'b0, ball_y} + BALL_SZ > {1'b0, paddle_l_y}) &&
                    ({1'b0, ball_y} < {1'b0, paddle_l_y} + PAD_H);
        overlap_r = ({1'b0, ball_y} + BALL_SZ > {1'b0, paddle_r_y}) &&
                    ({1'b0, ball_y} < {1'b0, paddle_r_y} + PAD_H);
        hit_l     = (dx == DIR_NEG) && (step_x <= L_FACE) && overlap_l;
        hit_r     = (dx == DIR_POS) && (step_x >= R_STOP) && overlap_r;
    end

    always_comb begin
        state_n     = state;
        ball_x_n    = ball_x;
        ball_y_n    = ball_y;
        dx_n        = dx;
        dy_n        = dy;
        score_l_n   = score_l;
        score_r_n   = score_r;
        winner_n    = winner;
        serve_cnt_n = serve_cnt;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n     = SERVE;
                    score_l_n   = 4'd0;
                    score_r_n   = 4'd0;
                    serve_cnt_n = '0;
                end
            end
            SERVE: begin
                ball_x_n = CENTRE_X;
                ball_y_n = CENTRE_Y;
                if (serve_cnt == SERVE_LAST) begin
                    state_n     = PLAY;
                    serve_cnt_n = '0;
                end else begin
                    serve_cnt_n = serve_cnt + 1'b1;
                end
            end
            PLAY: begin
                if (step_y <= 11'sd0) begin
                    ball_y_n = 10'd0;
                    dy_n     = DIR_POS;
                end else if (step_y >= BALL_MAX_Y) begin
                    ball_y_n = BALL_MAX_Y[9:0];
                    dy_n     = DIR_NEG;
                end else begin
                    ball_y_n = step_y[9:0];
                end

                if (hit_l) begin
                    ball_x_n = L_FACE[9:0];
                    dx_n     = DIR_POS;
                end else if (hit_r) begin
                    ball_x_n = R_STOP[9:0];
                    dx_n     = DIR_NEG;
                end else if (step_x <= 11'sd0) begin
                    // Left conceded: re-serve toward the left player.
                    score_r_n = score_r + 4'd1;
                    ball_x_n  = CENTRE_X;
                    ball_y_n  = CENTRE_Y;
                    dx_n      = DIR_NEG;
                    if (score_r_n == WIN) begin
                        state_n  = OVER;
                        winner_n = 1'b1;
                    end else begin
                        state_n = SERVE;
                    end
                end else if (step_x >= BALL_MAX_X) begin
                    score_l_n = score_l + 4'd1;
                    ball_x_n  = CENTRE_X;
                    ball_y_n  = CENTRE_Y;
                    dx_n      = DIR_POS;
                    if (score_l_n == WIN) begin
                        state_n  = OVER;
                        winner_n = 1'b0;
                    end else begin
                        state_n = SERVE;
                    end
                end else begin
                    ball_x_n = step_x[9:0];
                end
            end
            OVER: begin
                ball_x_n = CENTRE_X;
                ball_y_n = CENTRE_Y;
                if (start) begin
                    state_n     = SERVE;
                    score_l_n   = 4'd0;
                    score_r_n   = 4'd0;
                    serve_cnt_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ball_x    <= CENTRE_X;
            ball_y    <= CENTRE_Y;
            dx        <= DIR_POS;
            dy        <= DIR_POS;
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            winner    <= 1'b0;
            serve_cnt <= '0;
        end else if (frame_tick) begin
            state     <= state_n;
            ball_x    <= ball_x_n;
            ball_y    <= ball_y_n;
            dx        <= dx_n;
            dy        <= dy_n;
            score_l   <= score_l_n;
            score_r   <= score_r_n;
            winner    <= winner_n;
            serve_cnt <= serve_cnt_n;
        end
    end

    assign game_state = state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl against an integer game model driven by random and steered play.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       start;
    logic       btn_l_up, btn_l_dn, btn_r_up, btn_r_dn;
    logic [9:0] paddle_l_y, paddle_r_y, ball_x, ball_y;
    logic [3:0] score_l, score_r;
    logic [1:0] game_state;
    logic       winner;

    int compared   = 0;
    int mismatched = 0;

    // Integer game model: state 0..3, directions as +1/-1.
    int m_state, m_pl, m_pr, m_bx, m_by, m_dx, m_dy, m_sl, m_sr, m_cnt, m_win;
    bit m_hit_l;

    localparam logic [50:0] RESET_VEC = {10'd208, 10'd208, 10'd316, 10'd236, 4'd0, 4'd0, 2'd0, 1'b0};

    wire [50:0] dut_vec = {paddle_l_y, paddle_r_y, ball_x, ball_y, score_l, score_r, game_state, winner};

    always #5 clk = ~clk;

    pong_game_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start      (start),
        .btn_l_up   (btn_l_up),
        .btn_l_dn   (btn_l_dn),
        .btn_r_up   (btn_r_up),
        .btn_r_dn   (btn_r_dn),
        .paddle_l_y (paddle_l_y),
        .paddle_r_y (paddle_r_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_state (game_state),
        .winner     (winner)
    );

    function automatic logic [50:0] exp_vec();
        return {10'(m_pl), 10'(m_pr), 10'(m_bx), 10'(m_by), 4'(m_sl), 4'(m_sr), 2'(m_state), 1'(m_win)};
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic bit overlaps(input int by, input int py);
        return (by + 8 > py) && (by < py + 64);
    endfunction

    task automatic model_reset();
        m_state = 0; m_pl = 208; m_pr = 208; m_bx = 316; m_by = 236;
        m_dx = 1; m_dy = 1; m_sl = 0; m_sr = 0; m_cnt = 0; m_win = 0; m_hit_l = 0;
    endtask

    task automatic model_step(input bit st, input bit lu, input bit ld, input bit ru, input bit rd);
        int pl0, pr0, bx0, by0, nx, ny;
        pl0 = m_pl; pr0 = m_pr; bx0 = m_bx; by0 = m_by;
        m_hit_l = 0;
        if (m_state == 1 || m_state == 2) begin
            m_pl = clampi(m_pl + 4 * (int'(ld) - int'(lu)), 0, 416);
            m_pr = clampi(m_pr + 4 * (int'(rd) - int'(ru)), 0, 416);
        end
        case (m_state)
            0: if (st) begin m_state = 1; m_sl = 0; m_sr = 0; m_cnt = 0; end
            1: begin
                m_bx = 316; m_by = 236;
                if (m_cnt == 59) begin m_state = 2; m_cnt = 0; end
                else m_cnt++;
            end
            2: begin
                nx = bx0 + 2 * m_dx;
                ny = by0 + 2 * m_dy;
                if (ny <= 0) begin m_by = 0; m_dy = 1; end
                else if (ny >= 472) begin m_by = 472; m_dy = -1; end
                else m_by = ny;
                if (m_dx < 0 && nx <= 24 && overlaps(by0, pl0)) begin
                    m_bx = 24; m_dx = 1; m_hit_l = 1;
                end else if (m_dx > 0 && nx >= 608 && overlaps(by0, pr0)) begin
                    m_bx = 608; m_dx = -1;
                end else if (nx <= 0) begin
                    m_sr++; m_bx = 316; m_by = 236; m_dx = -1;
                    if (m_sr == 9) begin m_state = 3; m_win = 1; end else m_state = 1;
                end else if (nx >= 632) begin
                    m_sl++; m_bx = 316; m_by = 236; m_dx = 1;
                    if (m_sl == 9) begin m_state = 3; m_win = 0; end else m_state = 1;
                end else begin
                    m_bx = nx;
                end
            end
            default: if (st) begin
                m_state = 1; m_sl = 0; m_sr = 0; m_cnt = 0; m_pl = 208; m_pr = 208;
            end
        endcase
    endtask

    // One frame: inputs applied with frame_tick for 'hold' cycles, then random noise between ticks.
    task automatic do_tick(input bit st, input bit lu, input bit ld, input bit ru, input bit rd, input int hold);
        @(negedge clk);
        start = st; btn_l_up = lu; btn_l_dn = ld; btn_r_up = ru; btn_r_dn = rd;
        frame_tick = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            model_step(st, lu, ld, ru, rd);
        end
        @(negedge clk);
        frame_tick = 1'b0;
        start = 1'($urandom); btn_l_up = 1'($urandom); btn_l_dn = 1'($urandom);
        btn_r_up = 1'($urandom); btn_r_dn = 1'($urandom);
    endtask

    // mode: 0 idle, 1 track ball, 2 park at top
    task automatic steer(input int mode_l, input int mode_r,
                         output bit lu, output bit ld, output bit ru, output bit rd);
        int tgt;
        tgt = m_by + 4 - 32;
        lu = (mode_l == 2) || (mode_l == 1 && m_pl > tgt + 3);
        ld = (mode_l == 1 && m_pl < tgt - 3);
        ru = (mode_r == 2) || (mode_r == 1 && m_pr > tgt + 3);
        rd = (mode_r == 1 && m_pr < tgt - 3);
    endtask

    task automatic test_reset();
        compared++;
        if (dut_vec !== RESET_VEC) begin
            mismatched++; $display("FAIL reset_values: got %h want %h", dut_vec, RESET_VEC);
        end
        for (int i = 0; i < 5; i++) begin
            do_tick(0, 0, 0, 0, 0, 1);
            compared++;
            if (dut_vec !== RESET_VEC) begin
                mismatched++; $display("FAIL idle_tick%0d: got %h want %h", i, dut_vec, RESET_VEC);
            end
        end
        repeat (4) @(negedge clk);
        compared++;
        if (dut_vec !== RESET_VEC) begin
            mismatched++; $display("FAIL between_ticks: got %h want %h", dut_vec, RESET_VEC);
        end
    endtask

    task automatic test_idle_paddles();
        do_tick(0, 1, 0, 0, 1, 1);
        do_tick(0, 0, 1, 1, 0, 1);
        compared++;
        if (paddle_l_y !== 10'd208 || paddle_r_y !== 10'd208) begin
            mismatched++; $display("FAIL idle_paddles: got %0d/%0d want 208/208", paddle_l_y, paddle_r_y);
        end
    endtask

    task automatic test_paddle_serve();
        do_tick(1, 1, 0, 0, 0, 1);
        compared++;
        if (game_state !== 2'd1 || paddle_l_y !== 10'd208) begin
            mismatched++; $display("FAIL start_to_serve: got st=%0d pl=%0d want st=1 pl=208", game_state, paddle_l_y);
        end
        for (int i = 0; i < 2; i++) begin
            do_tick(0, 1, 1, 1, 1, 1);
            compared++;
            if (paddle_l_y !== 10'd208 || paddle_r_y !== 10'd208) begin
                mismatched++; $display("FAIL both_held: got %0d/%0d want 208/208", paddle_l_y, paddle_r_y);
            end
        end
        for (int k = 1; k <= 55; k++) begin
            do_tick(0, 1, 0, 0, 0, 1);
            compared++;
            if (paddle_l_y !== 10'((k <= 52) ? 208 - 4 * k : 0)) begin
                mismatched++; $display("FAIL paddle_up_%0d: got %0d want %0d", k, paddle_l_y, (k <= 52) ? 208 - 4 * k : 0);
            end
        end
    endtask

    task automatic test_play_entry();
        for (int i = 0; i < 3; i++) begin
            do_tick(0, 0, 0, 0, 0, 1);
            compared++;
            if (dut_vec !== exp_vec()) begin
                mismatched++; $display("FAIL serve_end_%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        compared++;
        if (game_state !== 2'd2) begin
            mismatched++; $display("FAIL enter_play: got %0d want 2", game_state);
        end
        do_tick(0, 0, 0, 0, 0, 1);
        compared++;
        if (ball_x !== 10'd318 || ball_y !== 10'd238) begin
            mismatched++; $display("FAIL first_play: got (%0d,%0d) want (318,238)", ball_x, ball_y);
        end
        for (int i = 0; i < 117; i++) begin
            do_tick(0, 0, 0, 0, 0, 1);
            compared++;
            if (dut_vec !== exp_vec()) begin
                mismatched++; $display("FAIL fall_%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        compared++;
        if (ball_y !== 10'd472) begin
            mismatched++; $display("FAIL bottom_clamp: got %0d want 472", ball_y);
        end
        do_tick(0, 0, 0, 0, 0, 1);
        compared++;
        if (ball_y !== 10'd470) begin
            mismatched++; $display("FAIL bottom_bounce: got %0d want 470", ball_y);
        end
    endtask

    task automatic test_right_miss();
        bit lu, ld, ru, rd;
        int n = 0;
        while (m_sl == 0 && n < 400) begin
            steer(0, 2, lu, ld, ru, rd);
            do_tick(0, lu, ld, ru, rd, 1);
            compared++;
            if (dut_vec !== exp_vec()) begin
                mismatched++; $display("FAIL rally_r_%0d: got %h want %h", n, dut_vec, exp_vec());
            end
            n++;
        end
        compared++;
        if (score_l !== 4'd1 || game_state !== 2'd1 || ball_x !== 10'd316 || ball_y !== 10'd236) begin
            mismatched++;
            $display("FAIL right_miss: got sl=%0d st=%0d ball=(%0d,%0d) want sl=1 st=1 ball=(316,236) n=%0d",
                     score_l, game_state, ball_x, ball_y, n);
        end
        repeat (61) do_tick(0, 0, 0, 0, 0, 1);
        compared++;
        if (ball_x !== 10'd318 || game_state !== 2'd2) begin
            mismatched++; $display("FAIL reserve_dir: got x=%0d st=%0d want x=318 st=2", ball_x, game_state);
        end
    endtask

    task automatic test_left_bounce();
        bit lu, ld, ru, rd;
        int n = 0;
        while (!m_hit_l && n < 1500) begin
            steer(1, 1, lu, ld, ru, rd);
            do_tick(0, lu, ld, ru, rd, 1);
            compared++;
            if (dut_vec !== exp_vec()) begin
                mismatched++; $display("FAIL rally_l_%0d: got %h want %h", n, dut_vec, exp_vec());
            end
            n++;
        end
        compared++;
        if (ball_x !== 10'd24 || score_l !== 4'd1 || score_r !== 4'd0 || !m_hit_l) begin
            mismatched++;
            $display("FAIL left_bounce: got x=%0d score=%0d/%0d want x=24 score=1/0 n=%0d", ball_x, score_l, score_r, n);
        end
        steer(1, 1, lu, ld, ru, rd);
        do_tick(0, lu, ld, ru, rd, 1);
        compared++;
        if (ball_x !== 10'd26) begin
            mismatched++; $display("FAIL after_bounce: got %0d want 26", ball_x);
        end
    endtask

    task automatic test_win();
        bit lu, ld, ru, rd;
        int n = 0;
        while (m_state != 3 && n < 6000) begin
            steer(1, 2, lu, ld, ru, rd);
            do_tick(0, lu, ld, ru, rd, 1);
            compared++;
            if (dut_vec !== exp_vec()) begin
                mismatched++; $display("FAIL rally_w_%0d: got %h want %h", n, dut_vec, exp_vec());
            end
            n++;
        end
        compared++;
        if (game_state !== 2'd3 || winner !== 1'b0 || score_l !== 4'd9 || ball_x !== 10'd316 || ball_y !== 10'd236) begin
            mismatched++;
            $display("FAIL game_over: got st=%0d win=%0d sl=%0d ball=(%0d,%0d) want st=3 win=0 sl=9 ball=(316,236) n=%0d",
                     game_state, winner, score_l, ball_x, ball_y, n);
        end
        for (int i = 0; i < 3; i++) begin
            do_tick(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1);
            compared++;
            if (dut_vec !== exp_vec() || ball_x !== 10'd316 || game_state !== 2'd3) begin
                mismatched++; $display("FAIL over_frozen_%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        do_tick(1, 1, 0, 0, 1, 1);
        compared++;
        if (game_state !== 2'd1 || score_l !== 4'd0 || score_r !== 4'd0 ||
            paddle_l_y !== 10'd208 || paddle_r_y !== 10'd208) begin
            mismatched++;
            $display("FAIL restart: got st=%0d score=%0d/%0d pad=%0d/%0d want st=1 score=0/0 pad=208/208",
                     game_state, score_l, score_r, paddle_l_y, paddle_r_y);
        end
    endtask

    task automatic test_back_to_back();
        do_tick(0, 0, 1, 0, 0, 3);
        compared++;
        if (paddle_l_y !== 10'd220 || dut_vec !== exp_vec()) begin
            mismatched++; $display("FAIL held_tick: got pl=%0d vec=%h want pl=220 vec=%h", paddle_l_y, dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            do_tick(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 9) == 0) ? 2 : 1);
            compared++;
            if (dut_vec !== exp_vec()) begin
                mismatched++; $display("FAIL random_%0d: got %h want %h", n, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_mid_reset();
        int n = 0;
        while (m_state != 2 && n < 200) begin
            do_tick(m_state == 3 || m_state == 0, 0, 0, 0, 0, 1);
            n++;
        end
        repeat (5) do_tick(0, 0, 0, 0, 0, 1);
        compared++;
        if (game_state !== 2'd2) begin
            mismatched++; $display("FAIL reach_play: got %0d want 2", game_state);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        compared++;
        if (dut_vec !== RESET_VEC) begin
            mismatched++; $display("FAIL async_reset: got %h want %h", dut_vec, RESET_VEC);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        do_tick(0, 1, 0, 1, 0, 1);
        compared++;
        if (dut_vec !== exp_vec()) begin
            mismatched++; $display("FAIL post_reset: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; start = 1'b0;
        btn_l_up = 1'b0; btn_l_dn = 1'b0; btn_r_up = 1'b0; btn_r_dn = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_idle_paddles();
        test_paddle_serve();
        test_play_entry();
        test_right_miss();
        test_left_bounce();
        test_win();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
